// File: rtl/rv_fetch_stage.sv
// ---------------------------------------------------------------------------
// rv_fetch_stage
//   Instruction fetch stage of the RV32IM core. Owns the PC, issues word
//   requests on the instruction memory port (in-order, no grant) and queues
//   {pc, instr} pairs in a small FIFO feeding decode. A redirect flushes the
//   FIFO and arms a drop counter so responses to requests issued before the
//   redirect are discarded as they return.
//
// Ports
//   clk_i            clock, all logic on rising edge
//   rst_i            synchronous active-high reset
//   boot_addr_i      PC loaded on reset
//   instr_req_o      fetch request (accepted in the cycle asserted)
//   instr_addr_o     fetch address, word aligned
//   instr_rvalid_i   response valid, in request order
//   instr_rdata_i    response instruction word
//   f_valid_o        FIFO head holds a valid instruction
//   f_instr_o        head instruction (0 when !f_valid_o)
//   f_current_pc_o   head PC (0 when !f_valid_o)
//   cu_stall_f_i     decode stall: head not consumed this cycle
//   cu_redirect_i    flush + redirect
//   cu_redirect_pc_i redirect target, bits[1:0] ignored
// ---------------------------------------------------------------------------
module rv_fetch_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] boot_addr_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  output logic            f_valid_o,
  output logic [XLEN-1:0] f_instr_o,
  output logic [XLEN-1:0] f_current_pc_o,
  input  logic            cu_stall_f_i,
  input  logic            cu_redirect_i,
  input  logic [XLEN-1:0] cu_redirect_pc_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C   = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(3));

  logic [XLEN-1:0] pc;

  // PCs of requests in flight, in issue order; entries are popped by every
  // response (dropped or not) so the queue stays aligned with the memory.
  logic [XLEN-1:0] pend_pc [DEPTH];
  logic [PW-1:0]   pend_wr;
  logic [PW-1:0]   pend_rd;

  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [XLEN-1:0] fifo_instr [DEPTH];
  logic [PW-1:0]   fifo_wr;
  logic [PW-1:0]   fifo_rd;

  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;

  logic            pop;
  logic            push;
  logic [CW:0]     occupancy;

  // Issue / consume decisions for the current cycle
  always_comb begin
    f_valid_o      = !rst_i && (count != '0);
    pop            = f_valid_o && !cu_stall_f_i && !cu_redirect_i;
    // Every slot is reserved at issue time, so a request is only made when
    // its response is guaranteed a FIFO entry.
    occupancy      = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
    instr_req_o    = !rst_i && !cu_redirect_i && (occupancy < DEPTH_C);
    push           = instr_rvalid_i && !cu_redirect_i && (drop == '0);
    instr_addr_o   = pc;
    f_instr_o      = f_valid_o ? fifo_instr[fifo_rd] : '0;
    f_current_pc_o = f_valid_o ? fifo_pc[fifo_rd]    : '0;
  end

  // Control state update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc          <= boot_addr_i & WORD_MASK;
      pend_wr     <= '0;
      pend_rd     <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(instr_req_o) - CW'(instr_rvalid_i);
      if (instr_req_o) begin
        pc      <= pc + XLEN'(4);
        pend_wr <= pend_wr + 1'b1;
      end
      if (instr_rvalid_i) pend_rd <= pend_rd + 1'b1;

      if (cu_redirect_i) begin
        pc      <= cu_redirect_pc_i & WORD_MASK;
        count   <= '0;
        fifo_rd <= fifo_wr;
        // A response arriving in the redirect cycle is discarded here, so it
        // is not counted among the ones still to drop.
        drop    <= outstanding - CW'(instr_rvalid_i);
      end else begin
        if (instr_rvalid_i && (drop != '0)) drop <= drop - 1'b1;
        if (push) fifo_wr <= fifo_wr + 1'b1;
        if (pop)  fifo_rd <= fifo_rd + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage (no reset: validity is tracked by the control pointers)
  always_ff @(posedge clk_i) begin
    if (instr_req_o) pend_pc[pend_wr] <= pc;
    if (push) begin
      fifo_pc[fifo_wr]    <= pend_pc[pend_rd];
      fifo_instr[fifo_wr] <= instr_rdata_i;
    end
  end

  // A response with nothing in flight means the memory side is broken.
  always_ff @(posedge clk_i) begin
    if (!rst_i && instr_rvalid_i) assert (outstanding != '0);
  end

endmodule

// File: tb/tb_rv_fetch_stage.sv
module tb_rv_fetch_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [XLEN-1:0] boot_addr_i;
  logic            instr_req_o;
  logic [XLEN-1:0] instr_addr_o;
  logic            instr_rvalid_i;
  logic [XLEN-1:0] instr_rdata_i;
  logic            f_valid_o;
  logic [XLEN-1:0] f_instr_o;
  logic [XLEN-1:0] f_current_pc_o;
  logic            cu_stall_f_i;
  logic            cu_redirect_i;
  logic [XLEN-1:0] cu_redirect_pc_i;

  rv_fetch_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .boot_addr_i      (boot_addr_i),
    .instr_req_o      (instr_req_o),
    .instr_addr_o     (instr_addr_o),
    .instr_rvalid_i   (instr_rvalid_i),
    .instr_rdata_i    (instr_rdata_i),
    .f_valid_o        (f_valid_o),
    .f_instr_o        (f_instr_o),
    .f_current_pc_o   (f_current_pc_o),
    .cu_stall_f_i     (cu_stall_f_i),
    .cu_redirect_i    (cu_redirect_i),
    .cu_redirect_pc_i (cu_redirect_pc_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory: in-order queue of accepted requests with the cycle they may return.
  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mreq_t;
  mreq_t mq[$];

  // Reference model: PC, queue of in-flight PCs, FIFO of {pc, instr}, drop count.
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  logic [63:0] m_fifo[$];
  int          m_drop;
  bit          m_valid, m_pop, m_req;
  logic [31:0] m_cpc, m_instr;

  bit          c_rst, c_stall, c_redir, c_rv;
  logic [31:0] c_rpc, c_rdata;

  task automatic model_eval();
    m_valid = !c_rst && (m_fifo.size() > 0);
    m_pop   = m_valid && !c_stall && !c_redir;
    m_req   = !c_rst && !c_redir && ((m_pend.size() + m_fifo.size() - int'(m_pop)) < DEPTH);
    m_cpc   = m_valid ? m_fifo[0][63:32] : 32'h0;
    m_instr = m_valid ? m_fifo[0][31:0]  : 32'h0;
  endtask

  task automatic model_update();
    logic [31:0] p;
    if (c_rst) begin
      m_pc = boot_addr_i & ~32'h3;
      m_pend.delete();
      m_fifo.delete();
      m_drop = 0;
    end else begin
      if (m_pop) void'(m_fifo.pop_front());
      if (c_rv && (m_pend.size() > 0)) begin
        p = m_pend.pop_front();
        if (!c_redir) begin
          if (m_drop > 0) m_drop--;
          else m_fifo.push_back({p, c_rdata});
        end
      end
      if (c_redir) begin
        m_fifo.delete();
        m_drop = m_pend.size();
        m_pc   = c_rpc & ~32'h3;
      end else if (m_req) begin
        m_pend.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Apply inputs just after a rising edge, then move to the falling edge.
  task automatic drive(input bit rst, input bit stall, input bit redir,
                       input logic [31:0] rpc, input bit want_rv);
    c_rst   = rst;
    c_stall = stall;
    c_redir = redir;
    c_rpc   = rpc;
    c_rv    = want_rv && !rst && (mq.size() > 0);
    c_rdata = c_rv ? word_at(mq[0].addr) : $urandom();
    rst_i            = c_rst;
    cu_stall_f_i     = c_stall;
    cu_redirect_i    = c_redir;
    cu_redirect_pc_i = c_rpc;
    instr_rvalid_i   = c_rv;
    instr_rdata_i    = c_rdata;
    model_eval();
    #4;
  endtask

  task automatic finish_cycle(input int lat);
    logic        dreq;
    logic [31:0] daddr;
    dreq  = instr_req_o;
    daddr = instr_addr_o;
    @(posedge clk);
    if (c_rst) mq.delete();
    else begin
      if (c_rv) void'(mq.pop_front());
      if (dreq) mq.push_back('{daddr, cyc + lat});
    end
    model_update();
    cyc++;
    #1;
  endtask

  typedef struct {
    bit          rst, stall, redir;
    logic [31:0] rpc;
    bit          rv;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit stall, input bit redir,
                              input logic [31:0] rpc, input bit rv, input bit e_req,
                              input logic [31:0] e_addr, input bit e_valid,
                              input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc; v.rv = rv;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  vec_t tab[$];

  initial begin
    rst_i = 1'b1; boot_addr_i = 32'h000100dc; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    cu_stall_f_i = 1'b0; cu_redirect_i = 1'b0; cu_redirect_pc_i = '0;

    //              rst st rd rpc           rv  req addr          vld pc
    tab.push_back(mk(1, 0, 0, 32'h0,        0,  0, 32'h0,         0, 32'h0));        // reset
    tab.push_back(mk(0, 0, 0, 32'h0,        0,  1, 32'h000100dc,  0, 32'h0));        // boot fetch
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h000100e0,  0, 32'h0));
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h000100e4,  1, 32'h000100dc));
    tab.push_back(mk(0, 0, 1, 32'h00020002, 0,  0, 32'h0,         1, 32'h000100e0)); // redirect, 1 in flight
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h00020000,  0, 32'h0));        // stale resp dropped
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h00020004,  0, 32'h0));
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h00020008,  1, 32'h00020000));
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h0002000c,  1, 32'h00020004));
    tab.push_back(mk(0, 1, 0, 32'h0,        1,  0, 32'h0,         1, 32'h00020008)); // stall, fills FIFO
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(0, 1, 0, 32'h0,      0,  0, 32'h0,         1, 32'h00020008)); // held while full
    tab.push_back(mk(0, 0, 0, 32'h0,        0,  1, 32'h00020010,  1, 32'h00020008)); // release
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h00020014,  1, 32'h0002000c));
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h00020018,  1, 32'h00020010));
    tab.push_back(mk(0, 1, 1, 32'hffffffff, 1,  0, 32'h0,         1, 32'h00020014)); // redirect+rvalid+stall
    tab.push_back(mk(0, 0, 0, 32'h0,        0,  1, 32'hfffffffc,  0, 32'h0));
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h00000000,  0, 32'h0));        // PC wraps
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h00000004,  1, 32'hfffffffc));
    tab.push_back(mk(1, 0, 0, 32'h0,        0,  0, 32'h0,         0, 32'h0));        // reset mid-stream
    tab.push_back(mk(0, 0, 0, 32'h0,        0,  1, 32'h000100dc,  0, 32'h0));        // refetch from boot
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h000100e0,  0, 32'h0));
    tab.push_back(mk(0, 0, 0, 32'h0,        1,  1, 32'h000100e4,  1, 32'h000100dc));

    foreach (tab[i]) begin
      drive(tab[i].rst, tab[i].stall, tab[i].redir, tab[i].rpc, tab[i].rv);
      check("tab_req", 32'(instr_req_o), 32'(tab[i].e_req));
      if (tab[i].e_req) check("tab_addr", instr_addr_o, tab[i].e_addr);
      check("tab_valid", 32'(f_valid_o), 32'(tab[i].e_valid));
      check("tab_pc", f_current_pc_o, tab[i].e_pc);
      check("tab_instr", f_instr_o, tab[i].e_valid ? word_at(tab[i].e_pc) : 32'h0);
      finish_cycle(1);
    end

    // Reset with a new boot address, then random traffic against the model.
    boot_addr_i = $urandom();
    drive(1, 0, 0, 32'h0, 0);
    finish_cycle(1);
    for (int i = 0; i < 3000; i++) begin
      bit          r_rst, r_stall, r_redir;
      logic [31:0] r_pc;
      r_rst   = ($urandom_range(0, 149) == 0);
      r_stall = ($urandom_range(0, 9) < 3);
      r_redir = ($urandom_range(0, 19) == 0);
      r_pc    = ($urandom_range(0, 3) == 0) ? (32'hfffffff0 | 32'($urandom_range(0, 15)))
                                            : $urandom();
      if (r_rst) boot_addr_i = $urandom();
      drive(r_rst, r_stall, r_redir, r_pc, (mq.size() > 0) && (mq[0].ready <= cyc));
      check("rnd_req", 32'(instr_req_o), 32'(m_req));
      if (m_req) check("rnd_addr", instr_addr_o, m_pc);
      check("rnd_valid", 32'(f_valid_o), 32'(m_valid));
      check("rnd_pc", f_current_pc_o, m_cpc);
      check("rnd_instr", f_instr_o, m_instr);
      finish_cycle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
